// File: rtl/register_file_if.sv
// Register-file access bus: one write port and two combinational read ports.
//   master: drives RegWrite/WriteRegister/WriteData and both read indices,
//           receives ReadData1/ReadData2.
//   slave : the register file side of the same signals.
interface register_file_if #(
  parameter int unsigned N_BITS = 32
);
  logic              RegWrite;
  logic [4:0]        WriteRegister;
  logic [N_BITS-1:0] WriteData;
  logic [4:0]        ReadRegister1;
  logic [4:0]        ReadRegister2;
  logic [N_BITS-1:0] ReadData1;
  logic [N_BITS-1:0] ReadData2;

  modport master (
    output RegWrite,
    output WriteRegister,
    output WriteData,
    output ReadRegister1,
    output ReadRegister2,
    input  ReadData1,
    input  ReadData2
  );

  modport slave (
    input  RegWrite,
    input  WriteRegister,
    input  WriteData,
    input  ReadRegister1,
    input  ReadRegister2,
    output ReadData1,
    output ReadData2
  );
endinterface

// File: rtl/register_file.sv
// 32 x N_BITS MIPS-style register file.
//   clk   : single clock, all state changes on its rising edge.
//   reset : synchronous, active-low; loads 0 everywhere except $gp (28) and $sp (29).
//   bus   : register_file_if slave port, one write port plus two combinational
//           read ports with write-to-read bypass.
// Register 0 is hardwired to zero.
module register_file #(
  parameter int unsigned       N_BITS  = 32,
  parameter logic [N_BITS-1:0] SP_INIT = 32'h7FFF_EFFC,
  parameter logic [N_BITS-1:0] GP_INIT = 32'h1000_8000
) (
  input logic             clk,
  input logic             reset,
  register_file_if.slave  bus
);

  logic [N_BITS-1:0] regs_q [32];
  logic              write_en;

  // A write is only real outside reset and to a non-zero index; the bypass
  // uses the same qualifier so a discarded write is never forwarded.
  assign write_en = reset && bus.RegWrite && (bus.WriteRegister != 5'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[28] <= GP_INIT;
      regs_q[29] <= SP_INIT;
    end else if (write_en) begin
      regs_q[bus.WriteRegister] <= bus.WriteData;
    end
  end

  always_comb begin
    bus.ReadData1 = '0;
    if (bus.ReadRegister1 != 5'd0) begin
      if (write_en && (bus.WriteRegister == bus.ReadRegister1)) begin
        bus.ReadData1 = bus.WriteData;
      end else begin
        bus.ReadData1 = regs_q[bus.ReadRegister1];
      end
    end
  end

  always_comb begin
    bus.ReadData2 = '0;
    if (bus.ReadRegister2 != 5'd0) begin
      if (write_en && (bus.WriteRegister == bus.ReadRegister2)) begin
        bus.ReadData2 = bus.WriteData;
      end else begin
        bus.ReadData2 = regs_q[bus.ReadRegister2];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by
// random traffic, compared against an array-based model of the register file.
module tb_register_file;

  localparam int unsigned N_BITS = 32;
  localparam logic [31:0] SP_VAL = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_VAL = 32'h1000_8000;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;
  logic [31:0] model [32];

  register_file_if #(.N_BITS(N_BITS)) bus ();

  register_file #(
    .N_BITS (N_BITS),
    .SP_INIT(SP_VAL),
    .GP_INIT(GP_VAL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_read(input logic rst, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd,
                                           input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (rst && we && wa != 5'd0 && wa == ra) return wd;
    return model[ra];
  endfunction

  task automatic model_edge(input logic rst, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd);
    if (!rst) begin
      foreach (model[i]) model[i] = 32'h0;
      model[28] = GP_VAL;
      model[29] = SP_VAL;
    end else if (we && wa != 5'd0) begin
      model[wa] = wd;
    end
  endtask

  // Drive one cycle's inputs, check both read ports before the edge,
  // then take the edge and update the model.
  task automatic step(input string tag, input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    reset             = rst;
    bus.RegWrite      = we;
    bus.WriteRegister = wa;
    bus.WriteData     = wd;
    bus.ReadRegister1 = ra1;
    bus.ReadRegister2 = ra2;
    #1;
    check({tag, "_rd1"}, bus.ReadData1, exp_read(rst, we, wa, wd, ra1));
    check({tag, "_rd2"}, bus.ReadData2, exp_read(rst, we, wa, wd, ra2));
    @(posedge clk);
    model_edge(rst, we, wa, wd);
    @(negedge clk);
  endtask

  initial begin
    logic        r_rst;
    logic        r_we;
    logic [4:0]  r_wa;
    logic [31:0] r_wd;
    logic [4:0]  r_ra1;
    logic [4:0]  r_ra2;

    pass_cnt  = 0;
    total_cnt = 0;
    foreach (model[i]) model[i] = 32'h0;

    // First reset: outputs are undefined before this edge, so no checks.
    @(negedge clk);
    reset             = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.WriteRegister = 5'd0;
    bus.WriteData     = 32'h0;
    bus.ReadRegister1 = 5'd0;
    bus.ReadRegister2 = 5'd0;
    @(posedge clk);
    model_edge(1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);

    // Reset values.
    step("rst_sp_gp", 1'b1, 1'b0, 5'd0, 32'h0, 5'd29, 5'd28);
    check("rst_sp_const", bus.ReadData1, 32'h7FFF_EFFC);
    check("rst_gp_const", bus.ReadData2, 32'h1000_8000);
    step("rst_r5", 1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31);

    // Plain write then read on both ports.
    step("wr_r8", 1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd1, 5'd2);
    step("rd_r8", 1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
    check("rd_r8_const", bus.ReadData1, 32'hDEAD_BEEF);

    // Writes to register 0 are discarded and not bypassed.
    step("wr_r0", 1'b1, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
    step("rd_r0", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Bypass on port 1 only; port 2 sees the old value of r10.
    step("wr_r10", 1'b1, 1'b1, 5'd10, 32'h0BAD_F00D, 5'd0, 5'd0);
    step("byp_r9", 1'b1, 1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd10);
    step("rd_r9", 1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd10);
    check("rd_r9_const", bus.ReadData1, 32'hA5A5_A5A5);

    // All three ports on one index.
    step("byp_all", 1'b1, 1'b1, 5'd17, 32'h5555_AAAA, 5'd17, 5'd17);

    // Reset mid-operation with a write pending: no bypass, write discarded.
    step("rst_mid", 1'b0, 1'b1, 5'd8, 32'hFFFF_FFFF, 5'd8, 5'd9);
    step("after_rst", 1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd29);
    check("after_rst_r8_const", bus.ReadData1, 32'h0);

    // Back-to-back writes to r31.
    step("b2b_1", 1'b1, 1'b1, 5'd31, 32'h1, 5'd31, 5'd31);
    step("b2b_2", 1'b1, 1'b1, 5'd31, 32'h2, 5'd31, 5'd31);
    step("b2b_rd", 1'b1, 1'b0, 5'd31, 32'h3, 5'd31, 5'd31);
    check("b2b_rd_const", bus.ReadData2, 32'h2);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      r_rst = ($urandom_range(0, 39) != 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_wa  = 5'($urandom_range(0, 31));
      r_wd  = $urandom;
      r_ra1 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
      r_ra2 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
      step("rand", r_rst, r_we, r_wa, r_wd, r_ra1, r_ra2);
    end

    // Final sweep of stored contents.
    for (int i = 0; i < 32; i += 2) begin
      step("sweep", 1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
